// File: rtl/calc_vga_pkg.sv
// Shared definitions for the calculator VGA painters: glyph codes, colours
// and the result converter state encoding.
package calc_vga_pkg;

    localparam logic [3:0] GLYPH_DASH  = 4'hA;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    localparam logic [7:0] COLOR_WHITE = 8'b11111111;
    localparam logic [7:0] COLOR_GRAY  = 8'b10010010;
    localparam logic [7:0] COLOR_BLUE  = 8'b00000011;
    localparam logic [7:0] COLOR_BLACK = 8'b00000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } painter_state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 correction on every BCD digit, then a
// one-bit left shift bringing bit_in in at the bottom.
module bcd_dabble_step #(
    parameter int NUM_DIGITS = 10
) (
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    bit_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    carry_out
);

    logic [4*NUM_DIGITS-1:0] adj;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            assign d = bcd_in[4*gi +: 4];
            assign adj[4*gi +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
        end
    endgenerate

    // carry_out is the bit leaving the most significant digit
    assign {carry_out, bcd_out} = {adj, bit_in};

endmodule

// File: rtl/result_bcd_painter.sv
// Signed decimal result field: sequential binary-to-BCD conversion into a
// double-buffered digit store, painted from the hpos/vpos pixel counters.
module result_bcd_painter
    import calc_vga_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          NUM_DIGITS = 10,
    parameter int          X0         = 260,
    parameter int          Y0         = 172,
    parameter int          PITCH      = 16,
    parameter logic [7:0]  FG         = COLOR_BLACK,
    parameter logic [7:0]  BG         = COLOR_GRAY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             res_sign,
    input  logic [WIDTH-1:0] res_mag,
    input  logic [9:0]       hpos,
    input  logic [8:0]       vpos,
    input  logic [4:0]       glyph_bits,
    output logic [3:0]       glyph_code,
    output logic [2:0]       glyph_row,
    output logic             busy,
    output logic             ready,
    output logic             overflow,
    output logic             in_field,
    output logic [7:0]       rgb
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    painter_state_t  state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg;
    logic [BW-1:0]    bcd_reg;
    logic [CW-1:0]    cnt_reg;
    logic             sign_reg, wovf_reg;
    logic [3:0]       disp_reg [NUM_DIGITS];
    logic             disp_sign_reg;
    logic             busy_reg, ready_reg, ovf_reg;

    logic [BW-1:0]    bcd_step;
    logic             carry_step;
    logic [3:0]       commit_digit [NUM_DIGITS];
    logic             mag_nonzero;

    bcd_dabble_step #(.NUM_DIGITS(NUM_DIGITS)) u_step (
        .bcd_in    (bcd_reg),
        .bit_in    (shreg_reg[WIDTH-1]),
        .bcd_out   (bcd_step),
        .carry_out (carry_step)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (load) state_next = ST_SHIFT;
            ST_SHIFT:  if (!load && cnt_reg == CW'(1)) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Leading-zero suppression; the last digit always survives so 0 shows as "0"
    always_comb begin
        logic seen;
        seen        = 1'b0;
        mag_nonzero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            commit_digit[i] = bcd_reg[4*(NUM_DIGITS-1-i) +: 4];
            if (commit_digit[i] != 4'd0) mag_nonzero = 1'b1;
            if (commit_digit[i] != 4'd0 || i == NUM_DIGITS - 1) seen = 1'b1;
            if (wovf_reg)   commit_digit[i] = GLYPH_DASH;
            else if (!seen) commit_digit[i] = GLYPH_BLANK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            shreg_reg     <= '0;
            bcd_reg       <= '1;
            cnt_reg       <= '0;
            sign_reg      <= 1'b0;
            wovf_reg      <= 1'b0;
            disp_sign_reg <= 1'b0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) disp_reg[i] <= GLYPH_BLANK;
        end else begin
            state_reg <= state_next;
            if (state_reg != ST_COMMIT && load) begin
                // a load mid-conversion restarts with the newest operands
                shreg_reg <= res_mag;
                sign_reg  <= res_sign;
                bcd_reg   <= '0;
                wovf_reg  <= 1'b0;
                cnt_reg   <= CW'(WIDTH);
                busy_reg  <= 1'b1;
            end else if (state_reg == ST_SHIFT) begin
                bcd_reg   <= bcd_step;
                shreg_reg <= shreg_reg << 1;
                cnt_reg   <= cnt_reg - CW'(1);
                if (carry_step) wovf_reg <= 1'b1;
            end else if (state_reg == ST_COMMIT) begin
                for (int i = 0; i < NUM_DIGITS; i++) disp_reg[i] <= commit_digit[i];
                disp_sign_reg <= sign_reg && mag_nonzero && !wovf_reg;
                ovf_reg       <= wovf_reg;
                ready_reg     <= 1'b1;
                busy_reg      <= 1'b0;
            end
        end
    end

    assign busy     = busy_reg;
    assign ready    = ready_reg;
    assign overflow = ovf_reg;

    always_comb begin
        int   hx, vy, off;
        logic lit;
        hx         = int'(hpos);
        vy         = int'(vpos);
        off        = 0;
        lit        = 1'b0;
        in_field   = 1'b0;
        glyph_code = GLYPH_BLANK;
        glyph_row  = 3'd0;
        if (vy >= Y0 && vy < Y0 + 12) begin
            if (hx >= X0 - 10 && hx < X0 - 4) begin
                in_field   = 1'b1;
                glyph_row  = 3'((vy - Y0) / 2);
                glyph_code = disp_sign_reg ? GLYPH_DASH : GLYPH_BLANK;
                lit        = disp_sign_reg && vy >= Y0 + 4 && vy < Y0 + 6;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (hx >= X0 + PITCH * i && hx < X0 + PITCH * (i + 1)) begin
                    in_field   = 1'b1;
                    off        = hx - (X0 + PITCH * i);
                    glyph_code = disp_reg[i];
                    glyph_row  = 3'((vy - Y0) / 2);
                    // the inter-digit gap is background; blank never takes ink
                    if (off < 10 && disp_reg[i] != GLYPH_BLANK)
                        lit = glyph_bits[3'(off / 2)];
                end
            end
        end
        rgb = lit ? FG : BG;
    end

endmodule

// File: tb/tb_result_bcd_painter.sv
// Directed bench for result_bcd_painter: conversion latency, restart, zero,
// overflow, sign bar, glyph pixel scan and asynchronous reset.
module tb_result_bcd_painter;
    import calc_vga_pkg::*;

    localparam int         X0    = 260;
    localparam int         Y0    = 172;
    localparam int         PITCH = 16;
    localparam logic [7:0] FG    = 8'b00000000;
    localparam logic [7:0] BG    = 8'b10010010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        res_sign = 1'b0;
    logic [31:0] res_mag = '0;
    logic [9:0]  hpos = '0;
    logic [8:0]  vpos = '0;

    logic [4:0] gb10, gb9;
    logic [3:0] gc10, gc9;
    logic [2:0] gr10, gr9;
    logic       busy10, ready10, ovf10, inf10;
    logic       busy9, ready9, ovf9, inf9;
    logic [7:0] rgb10, rgb9;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // arbitrary but fixed font model standing in for the glyph ROM
    function automatic logic [4:0] font(input logic [3:0] code, input logic [2:0] row);
        logic [7:0] h;
        h = {code, 1'b0, row} * 8'd37 + 8'd91;
        return h[6:2];
    endfunction

    assign gb10 = font(gc10, gr10);
    assign gb9  = font(gc9, gr9);

    result_bcd_painter dut (
        .clk(clk), .reset(reset), .load(load), .res_sign(res_sign), .res_mag(res_mag),
        .hpos(hpos), .vpos(vpos), .glyph_bits(gb10), .glyph_code(gc10), .glyph_row(gr10),
        .busy(busy10), .ready(ready10), .overflow(ovf10), .in_field(inf10), .rgb(rgb10)
    );

    result_bcd_painter #(.NUM_DIGITS(9)) dut9 (
        .clk(clk), .reset(reset), .load(load), .res_sign(res_sign), .res_mag(res_mag),
        .hpos(hpos), .vpos(vpos), .glyph_bits(gb9), .glyph_code(gc9), .glyph_row(gr9),
        .busy(busy9), .ready(ready9), .overflow(ovf9), .in_field(inf9), .rgb(rgb9)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic s, input logic [31:0] m);
        res_sign = s;
        res_mag  = m;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic pixel(input int x, input int y);
        hpos = 10'(x);
        vpos = 9'(y);
        #1;
    endtask

    task automatic read_codes10(output logic [39:0] c);
        for (int i = 0; i < 10; i++) begin
            pixel(X0 + PITCH * i, Y0);
            c[39-4*i -: 4] = gc10;
        end
    endtask

    task automatic read_codes9(output logic [35:0] c);
        for (int i = 0; i < 9; i++) begin
            pixel(X0 + PITCH * i, Y0);
            c[35-4*i -: 4] = gc9;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [39:0] c10;
        logic [35:0] c9;
        logic        busy_all;
        logic [4:0]  f;
        int          fg_count;

        // reset state
        #2 reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", 64'(busy10), 64'd0);
        chk("rst_ready", 64'(ready10), 64'd0);
        chk("rst_ovf", 64'(ovf10), 64'd0);
        read_codes10(c10);
        chk("rst_codes", 64'(c10), 64'hFFFFFFFFFF);
        reset = 1'b0;
        tick();

        // 55 restarted by 77 five cycles later; 55 must never commit
        do_load(1'b0, 32'd55);
        busy_all = busy10;
        for (int k = 1; k <= 4; k++) begin tick(); busy_all &= busy10; end
        res_mag = 32'd77;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        busy_all &= busy10;
        for (int k = 6; k <= 33; k++) begin tick(); busy_all &= busy10; end
        chk("restart_no_early_ready", 64'(ready10), 64'd0);
        for (int k = 34; k <= 37; k++) begin tick(); busy_all &= busy10; end
        chk("restart_busy_held", 64'(busy_all), 64'd1);
        chk("restart_ready_32", 64'(ready10), 64'd0);
        tick();
        chk("restart_ready_33", 64'(ready10), 64'd1);
        chk("restart_busy_33", 64'(busy10), 64'd0);
        read_codes10(c10);
        chk("restart_codes", 64'(c10), 64'hFFFFFFFF77);

        // -0 shows as a lone 0 with no minus bar
        do_load(1'b1, 32'd0);
        for (int k = 1; k <= 32; k++) tick();
        chk("zero_busy_32", 64'(busy10), 64'd1);
        tick();
        chk("zero_busy_33", 64'(busy10), 64'd0);
        read_codes10(c10);
        chk("zero_codes", 64'(c10), 64'hFFFFFFFFF0);
        pixel(X0 - 8, Y0 + 4);
        chk("zero_no_bar", 64'(rgb10), 64'(BG));

        // negative full-width value, sign bar and glyph scan of digit 0
        do_load(1'b1, 32'd1234567890);
        for (int k = 1; k <= 33; k++) tick();
        read_codes10(c10);
        chk("neg_codes", 64'(c10), 64'h1234567890);
        pixel(X0 - 8, Y0 + 4);
        chk("neg_bar_on", 64'(rgb10), 64'(FG));
        pixel(X0 - 8, Y0 + 2);
        chk("neg_bar_off", 64'(rgb10), 64'(BG));
        for (int r = 0; r < 6; r++) begin
            f = font(4'd1, 3'(r));
            for (int k = 0; k < 5; k++) begin
                pixel(X0 + 2 * k, Y0 + 2 * r);
                chk($sformatf("scan_k%0d_r%0d", k, r), 64'(rgb10), 64'(f[k] ? FG : BG));
            end
        end
        pixel(X0 + 3, Y0 + 7);
        chk("glyph_row", 64'(gr10), 64'd3);
        pixel(X0 + 12, Y0);
        chk("gap_in_field", 64'(inf10), 64'd1);
        chk("gap_rgb", 64'(rgb10), 64'(BG));
        pixel(X0 + PITCH * 10 + 5, Y0);
        chk("outside_in_field", 64'(inf10), 64'd0);
        chk("outside_code", 64'(gc10), 64'hF);
        pixel(X0, Y0 + 12);
        chk("below_in_field", 64'(inf10), 64'd0);

        // maximum magnitude: fits 10 digits, overflows 9
        do_load(1'b1, 32'd4294967295);
        for (int k = 1; k <= 33; k++) tick();
        chk("max10_ovf", 64'(ovf10), 64'd0);
        read_codes10(c10);
        chk("max10_codes", 64'(c10), 64'h4294967295);
        chk("max9_ovf", 64'(ovf9), 64'd1);
        read_codes9(c9);
        chk("max9_codes", 64'(c9), 64'hAAAAAAAAA);
        pixel(X0 - 8, Y0 + 4);
        chk("max10_bar", 64'(rgb10), 64'(FG));
        chk("max9_sign_blank", 64'(rgb9), 64'(BG));

        // asynchronous reset in the middle of a conversion
        do_load(1'b0, 32'd42);
        for (int k = 1; k <= 9; k++) tick();
        #2 reset = 1'b1;
        #1;
        chk("areset_busy", 64'(busy10), 64'd0);
        chk("areset_ready", 64'(ready10), 64'd0);
        chk("areset_ovf9", 64'(ovf9), 64'd0);
        chk("areset_ready9", 64'(ready9), 64'd0);
        read_codes10(c10);
        chk("areset_codes", 64'(c10), 64'hFFFFFFFFFF);
        fg_count = 0;
        for (int x = X0 - 10; x < X0 + PITCH * 10; x++) begin
            pixel(x, Y0 + 4);
            if (rgb10 != BG) fg_count++;
        end
        chk("areset_field_bg", 64'(fg_count), 64'd0);
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
